vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/pixel_tick_gen.sv | 30 +++
 rtl/vga_sync_gen.sv | 91 +++++++++
 tb/tb_vga_sync_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480 @ 60 Hz VGA timing constants and shared types for the sync generator.
// The top module takes these as parameter defaults so the geometry can be overridden per instance.
package vga_timing_pkg;

  localparam int CLK_DIV   = 4;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a one-cycle pixel enable, high once every CLK_DIV clocks.
module pixel_tick_gen #(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign p_tick = (div_q == DIV_MAX);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters, registered active-low syncs, visible-area flag and frame pulse.
// Coordinates come straight from the counter registers so downstream logic sees them with no extra latency.
module vga_sync_gen #(
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_tick,
  output logic [9:0] x,
  output logic [9:0] y
);

  import vga_timing_pkg::*;

  localparam int LINE_PIXELS = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START    = H_DISPLAY + H_FRONT;
  localparam int HS_END      = HS_START + H_SYNC - 1;
  localparam int VS_START    = V_DISPLAY + V_FRONT;
  localparam int VS_END      = VS_START + V_SYNC - 1;

  localparam coord_t H_LAST = coord_t'(LINE_PIXELS - 1);
  localparam coord_t V_LAST = coord_t'(FRAME_LINES - 1);

  logic   tick;
  logic   h_last;
  logic   v_last;
  coord_t h_q, h_d;
  coord_t v_q, v_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick_gen (
    .clk   (clk),
    .reset (reset),
    .p_tick(tick)
  );

  // Syncs are decoded from the next-state counts so the registered pulses line up with x/y.
  always_comb begin
    h_last  = (h_q == H_LAST);
    v_last  = (v_q == V_LAST);
    h_d     = h_q;
    v_d     = v_q;
    if (tick) begin
      h_d = h_last ? '0 : h_q + coord_t'(1);
      if (h_last) begin
        v_d = v_last ? '0 : v_q + coord_t'(1);
      end
    end
    hsync_d = !in_window(h_d, HS_START, HS_END);
    vsync_d = !in_window(v_d, VS_START, VS_END);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign x          = h_q;
  assign y          = v_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign p_tick     = tick;
  assign video_on   = (h_q < coord_t'(H_DISPLAY)) && (v_q < coord_t'(V_DISPLAY));
  assign frame_tick = tick && h_last && v_last;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: a default 640x480 instance, a CLK_DIV=2 instance and a shrunken-geometry instance
// checked against a closed-form timing model through a scoreboard, plus table vectors and corner sequences.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       ft;
  } outs_t;

  typedef struct {
    int    inst;
    outs_t exp;
  } sb_t;

  typedef struct {
    int    k;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rstA = 1'b1;
  logic rstB = 1'b1;
  logic rstC = 1'b1;

  logic hsA, vsA, vonA, ptA, ftA;
  logic hsB, vsB, vonB, ptB, ftB;
  logic hsC, vsC, vonC, ptC, ftC;
  logic [9:0] xA, yA, xB, yB, xC, yC;
  outs_t oA, oB, oC;

  int compared = 0;
  int mismatched = 0;
  int kA = 0;
  int kB = 0;
  int kC = 0;
  sb_t sbq[$];
  vec_t vecs[$];

  bit monA = 1'b1;
  int hsLowA = 0, ptCntA = 0;
  int hsLowB = 0, ptCntB = 0;
  int vsLowC = 0, vonCntC = 0, ftCntC = 0;
  int ftKC[$];
  outs_t snapB1599, snapB1600;

  always #5 clk = ~clk;

  vga_sync_gen dutA (
    .clk(clk), .reset(rstA), .hsync(hsA), .vsync(vsA), .video_on(vonA),
    .p_tick(ptA), .frame_tick(ftA), .x(xA), .y(yA)
  );

  vga_sync_gen #(.CLK_DIV(2)) dutB (
    .clk(clk), .reset(rstB), .hsync(hsB), .vsync(vsB), .video_on(vonB),
    .p_tick(ptB), .frame_tick(ftB), .x(xB), .y(yB)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dutC (
    .clk(clk), .reset(rstC), .hsync(hsC), .vsync(vsC), .video_on(vonC),
    .p_tick(ptC), .frame_tick(ftC), .x(xC), .y(yC)
  );

  assign oA = {xA, yA, hsA, vsA, vonA, ptA, ftA};
  assign oB = {xB, yB, hsB, vsB, vonB, ptB, ftB};
  assign oC = {xC, yC, hsC, vsC, vonC, ptC, ftC};

  function automatic outs_t mk(input int xx, input int yy, input bit hs, input bit vs,
                               input bit von, input bit pt, input bit ft);
    outs_t r;
    r.x   = 10'(xx);
    r.y   = 10'(yy);
    r.hs  = hs;
    r.vs  = vs;
    r.von = von;
    r.pt  = pt;
    r.ft  = ft;
    return r;
  endfunction

  // Closed-form expectation after k clock edges since reset release.
  function automatic outs_t model(input int k, input int cdiv, input int hd, input int hf,
                                  input int hsw, input int hb, input int vd, input int vf,
                                  input int vsw, input int vb);
    int htot = hd + hf + hsw + hb;
    int vtot = vd + vf + vsw + vb;
    int pix  = k / cdiv;
    int xx   = pix % htot;
    int yy   = (pix / htot) % vtot;
    bit pt   = ((k % cdiv) == cdiv - 1);
    return mk(xx, yy,
              !(xx >= hd + hf && xx < hd + hf + hsw),
              !(yy >= vd + vf && yy < vd + vf + vsw),
              (xx < hd) && (yy < vd),
              pt,
              pt && (xx == htot - 1) && (yy == vtot - 1));
  endfunction

  function automatic outs_t expectFor(input int inst, input int k);
    case (inst)
      0:       return model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
      1:       return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33);
      default: return model(k, 2, 8, 2, 3, 2, 6, 2, 2, 2);
    endcase
  endfunction

  task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b, expected x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b",
               name, act.x, act.y, act.hs, act.vs, act.von, act.pt, act.ft,
               exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.pt, exp.ft);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance until instance A has seen k edges since reset release; a bounded wait.
  task automatic applyStimulus(input int k);
    int guard = 0;
    while (kA < k && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (kA < k) checkValue($sformatf("timeout waiting for kA=%0d", k), kA, k);
  endtask

  // Scoreboard producer: expected outputs for every instance after each edge.
  initial forever begin
    @(posedge clk);
    kA = rstA ? kA + 1 : 0;
    kB = rstB ? kB + 1 : 0;
    kC = rstC ? kC + 1 : 0;
    sbq.push_back('{0, expectFor(0, kA)});
    sbq.push_back('{1, expectFor(1, kB)});
    sbq.push_back('{2, expectFor(2, kC)});
  end

  // Scoreboard consumer: compare on the falling edge, away from the active edge.
  initial forever begin
    sb_t e;
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.inst)
        0:       checkOutput("sb dutA", oA, e.exp);
        1:       checkOutput("sb dutB", oB, e.exp);
        default: checkOutput("sb dutC", oC, e.exp);
      endcase
    end
  end

  // Window counters for sync widths, tick rates and frame pulses.
  initial forever begin
    @(negedge clk);
    if (monA && kA >= 1 && kA <= 3200) begin
      hsLowA += (hsA == 1'b0) ? 1 : 0;
      ptCntA += (ptA == 1'b1) ? 1 : 0;
    end
    if (kB >= 1 && kB <= 1600) begin
      hsLowB += (hsB == 1'b0) ? 1 : 0;
      ptCntB += (ptB == 1'b1) ? 1 : 0;
    end
    if (kB == 1599) snapB1599 = oB;
    if (kB == 1600) snapB1600 = oB;
    if (kC >= 1 && kC <= 720) begin
      vsLowC  += (vsC == 1'b0) ? 1 : 0;
      vonCntC += (vonC == 1'b1) ? 1 : 0;
      if (ftC) begin
        ftCntC++;
        ftKC.push_back(kC);
      end
    end
  end

  initial begin
    outs_t rstVal;
    rstVal = mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    vecs.push_back('{0,    mk(0,   0, 1, 1, 1, 0, 0)});
    vecs.push_back('{2,    mk(0,   0, 1, 1, 1, 0, 0)});
    vecs.push_back('{3,    mk(0,   0, 1, 1, 1, 1, 0)});
    vecs.push_back('{4,    mk(1,   0, 1, 1, 1, 0, 0)});
    vecs.push_back('{2559, mk(639, 0, 1, 1, 1, 1, 0)});
    vecs.push_back('{2560, mk(640, 0, 1, 1, 0, 0, 0)});
    vecs.push_back('{2623, mk(655, 0, 1, 1, 0, 1, 0)});
    vecs.push_back('{2624, mk(656, 0, 0, 1, 0, 0, 0)});
    vecs.push_back('{3007, mk(751, 0, 0, 1, 0, 1, 0)});
    vecs.push_back('{3008, mk(752, 0, 1, 1, 0, 0, 0)});
    vecs.push_back('{3199, mk(799, 0, 1, 1, 0, 1, 0)});
    vecs.push_back('{3200, mk(0,   1, 1, 1, 1, 0, 0)});

    #1;
    rstA = 1'b0;
    rstB = 1'b0;
    rstC = 1'b0;
    #1;
    checkOutput("async reset at start dutA", oA, rstVal);
    checkOutput("async reset at start dutC", oC, rstVal);
    @(negedge clk);
    @(negedge clk);
    #2;
    rstA = 1'b1;
    rstB = 1'b1;
    rstC = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].k);
      checkOutput($sformatf("vec%0d k=%0d", i, vecs[i].k), oA, vecs[i].exp);
    end

    @(negedge clk);
    #1;
    checkValue("dutA hsync low clk in line 0", hsLowA, 384);
    checkValue("dutA p_tick count in line 0", ptCntA, 800);
    checkValue("dutB hsync low clk in line 0", hsLowB, 192);
    checkValue("dutB p_tick count in line 0", ptCntB, 800);
    checkOutput("dutB last pixel of line 0", snapB1599, mk(799, 0, 1, 1, 0, 1, 0));
    checkOutput("dutB first pixel of line 1", snapB1600, mk(0, 1, 1, 1, 1, 0, 0));
    checkValue("dutC vsync low clk over 2 frames", vsLowC, 120);
    checkValue("dutC video_on clk over 2 frames", vonCntC, 192);
    checkValue("dutC frame_tick clk over 2 frames", ftCntC, 2);
    if (ftKC.size() >= 2) begin
      checkValue("dutC first frame_tick edge", ftKC[0], 359);
      checkValue("dutC frame period clk", ftKC[1] - ftKC[0], 360);
    end else begin
      checkValue("dutC frame_tick occurrences", ftKC.size(), 2);
    end

    // Mid-frame reset of dutA while hsync is low on line 1.
    monA = 1'b0;
    applyStimulus(6000);
    checkValue("dutA pre-reset x", int'(xA), 700);
    checkValue("dutA pre-reset y", int'(yA), 1);
    checkValue("dutA pre-reset hsync", int'(hsA), 0);
    #2;
    rstA = 1'b0;
    #1;
    checkOutput("dutA async mid-frame reset", oA, rstVal);
    @(negedge clk);
    checkOutput("dutA held in reset", oA, rstVal);
    @(negedge clk);
    #2;
    rstA = 1'b1;

    applyStimulus(3);
    checkOutput("dutA restart first p_tick", oA, mk(0, 0, 1, 1, 1, 1, 0));
    applyStimulus(2624);
    checkOutput("dutA restart hsync start", oA, mk(656, 0, 0, 1, 0, 0, 0));
    applyStimulus(3200);
    checkOutput("dutA restart line wrap", oA, mk(0, 1, 1, 1, 1, 0, 0));

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
